// File: rtl/dcache_direct_if.sv
// Pipeline-side and backing-memory-side signals of the direct-mapped data cache.
// The cache takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_direct_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;
    logic                  misalign;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  req, we, addr, wdata, funct3, mem_rdata, mem_ready,
        output rdata, stall, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
    );

    modport master (
        output req, we, addr, wdata, funct3, mem_rdata, mem_ready,
        input  rdata, stall, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads hit combinationally; misses fill through a one-word request/ready handshake.
module dcache_direct #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 6
) (
    input  logic             clk,
    input  logic             rst,
    dcache_direct_if.slave   bus
);
    localparam int LINES = 1 << SET_BITS;
    localparam int TAG_W = DATA_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q [LINES];
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINES-1:0]      valid_q;

    logic [SET_BITS-1:0]   idx;
    logic [TAG_W-1:0]      tag_in;
    logic [1:0]            off;
    logic                  hit;
    logic                  supported;
    logic                  misal;
    logic                  access_ok;

    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            ofs,
        input logic [2:0]            f3
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {ofs, 3'b000};
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b010:  return word;
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [1:0]            ofs,
        input logic [1:0]            size
    );
        logic [DATA_WIDTH-1:0] mask;
        case (size)
            2'b00:   mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
            2'b01:   mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
            default: mask = '1;
        endcase
        mask = mask << {ofs, 3'b000};
        return (word & ~mask) | ((wd << {ofs, 3'b000}) & mask);
    endfunction

    assign idx    = bus.addr[SET_BITS+1:2];
    assign tag_in = bus.addr[DATA_WIDTH-1:SET_BITS+2];
    assign off    = bus.addr[1:0];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

    always_comb begin
        supported = 1'b0;
        misal     = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: supported = 1'b1;
            3'b001, 3'b101: begin supported = 1'b1; misal = off[0]; end
            3'b010:         begin supported = 1'b1; misal = (off != 2'b00); end
            default:        supported = 1'b0;
        endcase
    end

    // Misaligned and unsupported accesses retire immediately without touching anything.
    assign access_ok = bus.req && supported && !misal;

    always_comb begin
        bus.rdata      = '0;
        bus.stall      = 1'b0;
        bus.misalign   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = 3'b000;
        case (state)
            IDLE: begin
                bus.misalign = bus.req && supported && misal;
                bus.stall    = access_ok && (bus.we || !hit);
                if (access_ok && !bus.we && hit)
                    bus.rdata = extract(data_q[idx], off, bus.funct3);
            end
            FILL: begin
                bus.stall      = 1'b1;
                bus.mem_req    = 1'b1;
                bus.mem_addr   = {bus.addr[DATA_WIDTH-1:2], 2'b00};
                bus.mem_funct3 = 3'b010;
            end
            WRITE: begin
                bus.stall      = 1'b1;
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = bus.addr;
                bus.mem_wdata  = bus.wdata;
                bus.mem_funct3 = bus.funct3;
            end
            default: bus.stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_ok) begin
                        if (bus.we)
                            state <= WRITE;
                        else if (!hit)
                            state <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        valid_q[idx] <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready)
                        state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage is not reset; reset only blocks an in-flight fill or merge.
    always_ff @(posedge clk) begin
        if (!rst && state == FILL && bus.mem_ready) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag_in;
        end else if (!rst && state == WRITE && bus.mem_ready && hit) begin
            data_q[idx] <= merge(data_q[idx], bus.wdata, off, bus.funct3[1:0]);
        end
    end
endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: a word memory model behind the handshake and a
// scoreboard of expected per-access results compared when the pipeline is released.
module tb_dcache_direct;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   wait_n   = 0;
    int   wcnt     = 0;
    bit   loaded   = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          stalls;
        int          mreqs;
        logic        mis;
        logic        mwe;
        logic [2:0]  mf3;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [1024];

    dcache_direct_if #(.DATA_WIDTH(32)) bus ();

    dcache_direct #(.DATA_WIDTH(32), .SET_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[17:16], a[9:2]};
    endfunction

    assign bus.mem_rdata = mem[midx(bus.mem_addr)];
    assign bus.mem_ready = bus.mem_req && (wcnt >= wait_n);

    // Memory model: preload once, then apply sized writes on accepted write requests.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[midx(32'h0001_0000)] <= 32'h8040_2010;
            mem[midx(32'h0002_0000)] <= 32'hCAFE_F00D;
            loaded <= 1'b1;
        end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
            case (bus.mem_funct3[1:0])
                2'b00:   mem[midx(bus.mem_addr)][8*bus.mem_addr[1:0] +: 8]  <= bus.mem_wdata[7:0];
                2'b01:   mem[midx(bus.mem_addr)][8*bus.mem_addr[1] +: 16]   <= bus.mem_wdata[15:0];
                default: mem[midx(bus.mem_addr)] <= bus.mem_wdata;
            endcase
        end
        if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
        else                               wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input int exp_st, input int exp_mr,
                          input logic exp_mis, input logic exp_mwe, input logic [2:0] exp_mf3);
        exp_t        e;
        int          st = 0;
        int          mr = 0;
        logic        done = 1'b0;
        logic        unstable = 1'b0;
        logic [31:0] a0 = '0;
        logic [31:0] rd = '0;
        logic        mis = 1'b0;
        logic        mwe = 1'b0;
        logic [2:0]  mf3 = '0;
        e.name = name; e.rdata = exp_rd; e.stalls = exp_st; e.mreqs = exp_mr;
        e.mis = exp_mis; e.mwe = exp_mwe; e.mf3 = exp_mf3;
        sb.push_back(e);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.funct3 = f3;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (mr == 0) a0 = bus.mem_addr;
                else if (bus.mem_addr !== a0) unstable = 1'b1;
                mr++;
                mwe = bus.mem_we;
                mf3 = bus.mem_funct3;
            end
            if (!bus.stall) begin
                done = 1'b1;
                rd   = bus.rdata;
                mis  = bus.misalign;
                break;
            end
            st++;
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        chk({e.name, "_done"}, 32'(done), 32'd1);
        chk({e.name, "_rdata"}, rd, e.rdata);
        chk({e.name, "_stalls"}, st, e.stalls);
        chk({e.name, "_mem_reqs"}, mr, e.mreqs);
        chk({e.name, "_misalign"}, 32'(mis), 32'(e.mis));
        chk({e.name, "_addr_stable"}, 32'(unstable), 32'd0);
        if (e.mreqs > 0) begin
            chk({e.name, "_mem_we"}, 32'(mwe), 32'(e.mwe));
            chk({e.name, "_mem_funct3"}, 32'(mf3), 32'(e.mf3));
        end
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.funct3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;

        access("cold_lw", 0, 32'h0001_0000, 0, 3'b010, 32'h8040_2010, 2, 1, 0, 0, 3'b010);
        access("lb",  0, 32'h0001_0003, 0, 3'b000, 32'hFFFF_FF80, 0, 0, 0, 0, 3'b000);
        access("lbu", 0, 32'h0001_0003, 0, 3'b100, 32'h0000_0080, 0, 0, 0, 0, 3'b000);
        access("lh",  0, 32'h0001_0002, 0, 3'b001, 32'hFFFF_8040, 0, 0, 0, 0, 3'b000);
        access("lhu", 0, 32'h0001_0000, 0, 3'b101, 32'h0000_2010, 0, 0, 0, 0, 3'b000);

        access("sb_hit", 1, 32'h0001_0001, 32'h0000_00AB, 3'b000, 32'h0, 2, 1, 0, 1, 3'b000);
        access("lw_after_sb", 0, 32'h0001_0000, 0, 3'b010, 32'h8040_AB10, 0, 0, 0, 0, 3'b000);

        access("sw_miss", 1, 32'h0001_0100, 32'h1234_5678, 3'b010, 32'h0, 2, 1, 0, 1, 3'b010);
        access("lw_after_sw", 0, 32'h0001_0100, 0, 3'b010, 32'h1234_5678, 2, 1, 0, 0, 3'b010);
        access("lw_evicted", 0, 32'h0001_0000, 0, 3'b010, 32'h8040_AB10, 2, 1, 0, 0, 3'b010);

        // Ready arrives three cycles after the access is presented.
        wait_n = 2;
        access("lw_wait", 0, 32'h0001_0100, 0, 3'b010, 32'h1234_5678, 4, 3, 0, 0, 3'b010);
        wait_n = 0;

        access("lw_misal", 0, 32'h0001_0002, 0, 3'b010, 32'h0, 0, 0, 1, 0, 3'b000);

        wait_n = 5;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0002_0000; bus.funct3 = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        chk("fill_mem_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.req = 1'b0;
        @(negedge clk);
        chk("rst_fill_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_fill_stall", 32'(bus.stall), 32'd0);
        wait_n = 0;
        @(posedge clk); #1;
        access("lw_after_rst", 0, 32'h0002_0000, 0, 3'b010, 32'hCAFE_F00D, 2, 1, 0, 0, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline memory stage and the byte-addressed data memory.
- Serves RISC-V loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw), selected by funct3.
- Issues a stall to the pipeline on misses and stores, and talks to the backing memory through a one-word request/ready handshake.

Parameters:
DATA_WIDTH  32  data and address width
SET_BITS    6   log2 of line count (64 one-word lines); index = addr[SET_BITS+1:2], tag = addr[31:SET_BITS+2]

Ports:
clk         input   1           clock, all state on rising edge
rst         input   1           synchronous active-high reset
req         input   1           memory-stage access valid
we          input   1           1 = store, 0 = load
addr        input   DATA_WIDTH  byte address
wdata       input   DATA_WIDTH  store data (low bytes used for sb/sh)
funct3      input   3           access size/sign, RISC-V encoding
rdata       output  DATA_WIDTH  load result, sign/zero extended
stall       output  1           pipeline must hold memory stage
misalign    output  1           access not naturally aligned
mem_req     output  1           backing-memory request valid
mem_we      output  1           backing-memory write
mem_addr    output  DATA_WIDTH  backing-memory byte address
mem_wdata   output  DATA_WIDTH  backing-memory write data
mem_funct3  output  3           backing-memory access size
mem_rdata   input   DATA_WIDTH  backing-memory read word (lw)
mem_ready   input   1           request accepted/completed this cycle

Behaviour:
- Storage: data array of 2^SET_BITS words, tag array, valid bit per line. Valid bits sit in a flop vector cleared by rst. Data and tag arrays are not reset.
- Hit definition: valid[index] and tag[index] == addr tag.
- Misalignment:
  - lh/lhu/sh with addr[0]=1 is misaligned.
  - lw/sw with addr[1:0]!=0 is misaligned.
  - On misalignment, misalign=1 combinationally while req and state IDLE.
  - A misaligned access has no memory access, no cache change, rdata=0, stall=0.
- Unsupported funct3 (011, 110, 111): treated as a no-op. rdata=0, stall=0, no memory access.
- FSM states: IDLE, FILL, WRITE, RESP. Reset puts the FSM in IDLE.
- IDLE:
  - Load hit: rdata is extracted combinationally from the line using addr[1:0] and funct3; stall=0.
  - Load miss: stall=1; next state FILL.
  - Store: stall=1; next state WRITE.
  - No req: stall=0.
- FILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}, mem_funct3=010; stall=1.
  - On a cycle with mem_ready=1: at that edge, data←mem_rdata, tag←addr tag, valid←1; next state IDLE.
  - The next cycle is a hit and returns stall=0.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata, mem_funct3=funct3; stall=1.
  - On mem_ready=1: if the access hits, merge only the addressed bytes (1/2/4) into the line at that edge. A miss leaves the cache unchanged. Next state RESP.
- RESP: stall=0 for exactly one cycle so the pipeline retires the store; next state IDLE.
- Handshake rules:
  - mem_* outputs are held stable while mem_req=1 until mem_ready.
  - mem_ready may be high in the same cycle mem_req rises; a combinational memory ties it high.
  - mem_ready is ignored when mem_req=0.
- Latency with mem_ready tied high:
  - Load hit: 0 stall cycles.
  - Load miss: 2 stall cycles.
  - Store: 2 stall cycles.
  - Each extra wait cycle on mem_ready adds one stall cycle.
- Reset values: stall=0, mem_req=0, mem_we=0, misalign=0, all lines invalid. rdata=0 when not (req & IDLE & hit).
- Reset mid-FILL or mid-WRITE: FSM returns to IDLE at that edge, and mem_req=0 from the next cycle. The line is not filled, and no partial byte merge occurs.
- Outside FILL/WRITE, mem_req=0 and the other mem_* outputs are 0.
- Conflict miss: a fill replaces the previous line with the same index unconditionally. No dirty state exists because the cache is write-through.

Test Plan:
- Cold load: after reset, lw addr 0x00010000, memory word 0x8040_2010, ready tied high. Required: stall high 2 cycles, one mem_req, then rdata=0x80402010 with stall=0.
- Sub-word extraction on a resident line 0x8040_2010 at 0x00010000:
  - lb 0x00010003 → 0xFFFFFF80.
  - lbu 0x00010003 → 0x00000080.
  - lh 0x00010002 → 0xFFFF8040.
  - lhu 0x00010000 → 0x00002010.
  - All four with no stall and no mem_req.
- Store hit: sb 0xAB to 0x00010001 on the resident line. Required: mem_req with mem_we=1 and mem_funct3=000, 2 stall cycles; then lw 0x00010000 → 0x8040AB10 with no memory access.
- Store miss: sw 0x12345678 to 0x00010100. Required: a memory write occurs; a following lw to that address misses (stall 2 cycles) and returns 0x12345678 from memory.
- Conflict and wait states:
  - lw 0x00010000, then lw 0x00010100 with SET_BITS=6 (same index). The second load misses and evicts; re-reading 0x00010000 misses again.
  - With mem_ready delayed 3 cycles, stall lasts 4 cycles and mem_addr stays stable throughout.
- Misalign and reset:
  - lw 0x00010002 → misalign=1, rdata=0, no mem_req.
  - Assert rst during FILL → mem_req low the next cycle, and a subsequent load to the same address misses.
